pbus_ctrl: RTL

//  Timing controller for the shared 16-bit peripheral bus (expansion slots 1/2, ethernet).

---
 rtl/pbus_pkg.sv | 35 +++
 rtl/pbus_timer.sv | 34 +++
 rtl/pbus_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pbus_pkg                                                   |
// | Desc    : Shared types and constants for the peripheral bus          |
// |           timing controller (state encoding, target selects).        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pbus_pkg;

  // Controller states; DONE is the single cycle in which wt is low.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    DONE   = 3'd4,
    HOLD   = 3'd5
  } pbus_state_t;

  // Target select codes; code 3 has no chip select behind it.
  typedef enum logic [1:0] {
    SEL_SLOT1   = 2'd0,
    SEL_SLOT2   = 2'd1,
    SEL_ETHER   = 2'd2,
    SEL_ILLEGAL = 2'd3
  } pbus_sel_t;

  // Read data returned for failed accesses.
  localparam logic [15:0] ERR_DATA = 16'hFFFF;

  // Width of the shared phase counter.
  localparam int CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/pbus_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pbus_timer                                                 |
// | Desc    : Loadable down-counter that saturates at zero; shared by    |
// |           the setup, strobe and hold phases of a pbus cycle.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pbus_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  // Load a new phase length, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/pbus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pbus_ctrl                                                  |
// | Desc    : Peripheral bus timing controller. Arbitrates for the pbus, |
// |           then runs setup/strobe/hold with ready stretching.         |
// |           Optional macro PBUS_TIMEOUT_EN adds a ready-wait timeout   |
// |           (TIMEOUT_CYC) that ends the access with ERR_DATA/bus_err.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pbus_ctrl
  import pbus_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
`ifdef PBUS_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 1024,
`endif
  parameter int HOLD_CYC    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        wr,
  input  logic [1:0]  sel,
  input  logic [4:0]  addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        wt,
  output logic        pbus_req,
  input  logic        pbus_gnt,
  output logic [4:0]  pbus_a,
  output logic [15:0] pbus_d_out,
  output logic        pbus_d_oe,
  input  logic [15:0] pbus_d_in,
  output logic        pbus_read_n,
  output logic        pbus_write_n,
  input  logic        pbus_ready,
  output logic        slot1_cs_n,
  output logic        slot2_cs_n,
  output logic        ether_cs_n,
  output logic        bus_err
);

  pbus_state_t      r_state;
  pbus_state_t      w_next;
  logic             r_wr;
  pbus_sel_t        r_sel;
  logic [4:0]       r_addr;
  logic [15:0]      r_data;
  logic [15:0]      r_dout;
  logic             r_err;
  logic             r_rdy_s1;
  logic             r_rdy_s2;
  logic             w_load;
  logic [CNT_W-1:0] w_value;
  logic             w_zero;
  logic             w_accept;
  logic             w_illegal;
  logic             w_rd_cap;
  logic             w_tmo_hit;
  logic             w_active;

  pbus_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_load),
    .value   (w_value),
    .zero    (w_zero)
  );

  // Two-flop synchroniser for the asynchronous target ready pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy_s1 <= 1'b0;
      r_rdy_s2 <= 1'b0;
    end else begin
      r_rdy_s1 <= pbus_ready;
      r_rdy_s2 <= r_rdy_s1;
    end
  end

`ifdef PBUS_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC) > 10) ? $clog2(TIMEOUT_CYC) : 10;
  logic [TMO_W-1:0] r_tmo;

  // Count cycles spent past the minimum strobe still waiting for ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo <= '0;
    end else if (r_state == STROBE && w_zero && !r_rdy_s2) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  assign w_tmo_hit = (r_state == STROBE) && w_zero && !r_rdy_s2 &&
                     (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, phase-counter loads and pbus outputs decoded from state.
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_value      = '0;
    w_accept     = 1'b0;
    w_illegal    = 1'b0;
    w_rd_cap     = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          if (pbus_sel_t'(sel) == SEL_ILLEGAL) begin
            w_illegal = 1'b1;
            w_next    = DONE;
          end else begin
            w_accept  = 1'b1;
            w_next    = REQ;
          end
        end
      end
      REQ: begin
        if (pbus_gnt) begin
          w_next  = SETUP;
          w_load  = 1'b1;
          w_value = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (w_zero) begin
          w_next  = STROBE;
          w_load  = 1'b1;
          w_value = CNT_W'(STROBE_CYC - 1);
        end
      end
      STROBE: begin
        if (w_zero && r_rdy_s2) begin
          w_next   = HOLD;
          w_load   = 1'b1;
          w_value  = CNT_W'(HOLD_CYC - 1);
          w_rd_cap = !r_wr;
        end else if (w_tmo_hit) begin
          w_next  = HOLD;
          w_load  = 1'b1;
          w_value = CNT_W'(HOLD_CYC - 1);
        end
      end
      HOLD: begin
        if (w_zero) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase

    // Outputs are pure state decode so an async reset releases the pads at once.
    w_active     = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);
    pbus_req     = w_active || (r_state == REQ);
    pbus_d_oe    = w_active && r_wr;
    pbus_read_n  = !((r_state == STROBE) && !r_wr);
    pbus_write_n = !((r_state == STROBE) && r_wr);
    slot1_cs_n   = !(w_active && (r_sel == SEL_SLOT1));
    slot2_cs_n   = !(w_active && (r_sel == SEL_SLOT2));
    ether_cs_n   = !(w_active && (r_sel == SEL_ETHER));
    wt           = (r_state != DONE);
  end

  // Request latch, read data capture and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr   <= 1'b0;
      r_sel  <= SEL_SLOT1;
      r_addr <= '0;
      r_data <= '0;
      r_dout <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr   <= wr;
        r_sel  <= pbus_sel_t'(sel);
        r_addr <= addr;
        r_data <= data_in;
        r_err  <= 1'b0;
      end
      if (w_rd_cap) begin
        r_dout <= pbus_d_in;
      end
      if (w_illegal || w_tmo_hit) begin
        r_dout <= ERR_DATA;
        r_err  <= 1'b1;
      end
    end
  end

  assign pbus_a     = r_addr;
  assign pbus_d_out = r_data;
  assign data_out   = r_dout;
  assign bus_err    = r_err;

endmodule
`default_nettype wire
